// File: rtl/conv_ctrl_pkg.sv
// Shared encodings for the convolution control block: MCU opcodes, FSM states
// and bit positions of the 32-bit status word returned by STATUS_READ.
package conv_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_KNL_LOAD     = 3'd0,
    OP_IMGSIZE_LOAD = 3'd1,
    OP_IMG_LOAD     = 3'd2,
    OP_DATA_REQ     = 3'd3,
    OP_GO_RUN       = 3'd4,
    OP_SOFT_RESET   = 3'd5,
    OP_STATUS_READ  = 3'd6,
    OP_ILLEGAL      = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_KNL = 3'd1,
    S_LOAD_IMG = 3'd2,
    S_RUN      = 3'd3,
    S_OUT      = 3'd4
  } state_e;

  localparam int STAT_W         = 32;
  localparam int STAT_STATE_LSB = 29;
  localparam int STAT_ERR_BIT   = 28;
  localparam int STAT_KFULL_BIT = 27;
  localparam int STAT_RUN_BIT   = 26;
  localparam int STAT_EOP_BIT   = 25;

endpackage

// File: rtl/gpio_edge_det.sv
// Registered rising-edge detector for the MCU command strobe. The armed flag
// keeps a strobe already high at reset release from being taken as an edge.
module gpio_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic rise_o
);

  logic armed_q;
  logic sig_q;
  logic rise_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      armed_q <= 1'b0;
      sig_q   <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      sig_q   <= sig_i;
      rise_q  <= armed_q & sig_i & ~sig_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/conv_ctrl_block.sv
// MCU command decoder and sequencing FSM for the convolution engine: kernel and
// image loading, run/end-of-processing handshake, readback and sticky errors.
module conv_ctrl_block
  import conv_ctrl_pkg::*;
#(
  parameter int NB_GPIO_DATA = 24,
  parameter int NB_MCU_DATA  = 13,
  parameter int N_KNL_ROWS   = 3,
  parameter int NB_IMGLEN    = 10,
  parameter int MAX_IMGLEN   = 1023
) (
  input  logic                          i_CLK,
  input  logic                          i_rst,
  input  logic [NB_GPIO_DATA-1:0]       i_GPIOdata,
  input  logic [2:0]                    i_GPIOctrl,
  input  logic                          i_GPIOvalid,
  input  logic [NB_MCU_DATA-1:0]        i_MCUdata,
  input  logic                          i_EOP_from_FSM,
  output logic [31:0]                   o_GPIOdata,
  output logic [NB_GPIO_DATA-1:0]       o_KNLdata,
  output logic [$clog2(N_KNL_ROWS)-1:0] o_knl_idx,
  output logic                          o_valid_to_CONV,
  output logic                          o_valid_to_FSM,
  output logic                          o_load,
  output logic                          o_run,
  output logic                          o_EOP_to_MCU,
  output logic                          o_KNorIMG,
  output logic                          o_error,
  output logic [NB_IMGLEN-1:0]          o_imgLength,
  output logic [2:0]                    o_state
);

  localparam int KIDX_W = $clog2(N_KNL_ROWS);
  localparam int PAD_W  = 32 - NB_MCU_DATA;
  localparam logic [NB_IMGLEN:0] MAX_LEN = (NB_IMGLEN+1)'(MAX_IMGLEN);

  state_e                  state_q, state_d;
  logic [KIDX_W-1:0]       knl_cnt_q, knl_cnt_d, knl_idx_q, knl_idx_d;
  logic                    knl_full_q, knl_full_d;
  logic [NB_GPIO_DATA-1:0] knl_data_q, knl_data_d;
  logic                    err_q, err_d, eop_q, eop_d;
  logic                    vconv_q, vconv_d, vfsm_q, vfsm_d, load_q, load_d;
  logic                    pend_q, pend_d;
  logic [NB_IMGLEN-1:0]    img_len_q, img_len_d, len_req;
  logic [31:0]             gpio_q, gpio_d, status_w;
  opcode_e                 cmd_op_q;
  logic [NB_GPIO_DATA-1:0] cmd_data_q;
  logic                    cmd_vld;

  gpio_edge_det u_edge (
    .clk_i  (i_CLK),
    .rst_ni (i_rst),
    .sig_i  (i_GPIOvalid),
    .rise_o (cmd_vld)
  );

  // Opcode and payload captured on the same edge as the strobe rise
  always_ff @(posedge i_CLK or negedge i_rst) begin
    if (!i_rst) begin
      cmd_op_q   <= OP_KNL_LOAD;
      cmd_data_q <= '0;
    end else begin
      cmd_op_q   <= opcode_e'(i_GPIOctrl);
      cmd_data_q <= i_GPIOdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    knl_cnt_d  = knl_cnt_q;
    knl_idx_d  = knl_idx_q;
    knl_full_d = knl_full_q;
    knl_data_d = knl_data_q;
    err_d      = err_q;
    eop_d      = eop_q;
    img_len_d  = img_len_q;
    gpio_d     = gpio_q;
    vconv_d    = 1'b0;
    vfsm_d     = 1'b0;
    load_d     = 1'b0;
    pend_d     = 1'b0;
    len_req    = cmd_data_q[NB_IMGLEN-1:0];

    status_w                           = '0;
    status_w[STAT_STATE_LSB +: 3]      = state_q;
    status_w[STAT_ERR_BIT]             = err_q;
    status_w[STAT_KFULL_BIT]           = knl_full_q;
    status_w[STAT_RUN_BIT]             = (state_q == S_RUN);
    status_w[STAT_EOP_BIT]             = eop_q;
    status_w[NB_IMGLEN-1:0]            = img_len_q;

    // Pixel readback lands one cycle after the DATA_REQ strobe to memory
    if (pend_q) gpio_d = {{PAD_W{1'b0}}, i_MCUdata};

    if (state_q == S_RUN && i_EOP_from_FSM) begin
      state_d = S_OUT;
      eop_d   = 1'b1;
    end

    if (cmd_vld) begin
      if (cmd_op_q == OP_SOFT_RESET) begin
        state_d    = S_IDLE;
        knl_cnt_d  = '0;
        knl_idx_d  = '0;
        knl_full_d = 1'b0;
        knl_data_d = '0;
        err_d      = 1'b0;
        eop_d      = 1'b0;
        gpio_d     = '0;
      end else if (state_q != S_RUN) begin
        case (cmd_op_q)
          OP_KNL_LOAD: begin
            if (state_q inside {S_IDLE, S_LOAD_KNL, S_OUT}) begin
              knl_data_d = cmd_data_q;
              knl_idx_d  = knl_cnt_q;
              vconv_d    = 1'b1;
              state_d    = S_LOAD_KNL;
              if (knl_cnt_q == KIDX_W'(N_KNL_ROWS-1)) begin
                knl_cnt_d  = '0;
                knl_full_d = 1'b1;
              end else begin
                knl_cnt_d = knl_cnt_q + KIDX_W'(1);
              end
            end else begin
              err_d = 1'b1;
            end
          end
          OP_IMGSIZE_LOAD: begin
            if (len_req != '0 && {1'b0, len_req} <= MAX_LEN) img_len_d = len_req;
            else err_d = 1'b1;
          end
          OP_IMG_LOAD: begin
            load_d  = (state_q != S_LOAD_IMG);
            vfsm_d  = 1'b1;
            eop_d   = 1'b0;
            state_d = S_LOAD_IMG;
          end
          OP_DATA_REQ: begin
            if (state_q == S_OUT) begin
              vfsm_d = 1'b1;
              pend_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
          OP_GO_RUN: begin
            if (state_q == S_LOAD_IMG && knl_full_q && img_len_q != '0) state_d = S_RUN;
            else err_d = 1'b1;
          end
          OP_STATUS_READ: begin
            gpio_d = status_w;
            err_d  = 1'b0;
          end
          default: err_d = 1'b1;
        endcase
      end
    end

    if (!(state_q inside {S_IDLE, S_LOAD_KNL, S_LOAD_IMG, S_RUN, S_OUT})) state_d = S_IDLE;
  end

  always_ff @(posedge i_CLK or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= S_IDLE;
      knl_cnt_q  <= '0;
      knl_idx_q  <= '0;
      knl_full_q <= 1'b0;
      knl_data_q <= '0;
      err_q      <= 1'b0;
      eop_q      <= 1'b0;
      img_len_q  <= '0;
      gpio_q     <= '0;
      vconv_q    <= 1'b0;
      vfsm_q     <= 1'b0;
      load_q     <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      knl_cnt_q  <= knl_cnt_d;
      knl_idx_q  <= knl_idx_d;
      knl_full_q <= knl_full_d;
      knl_data_q <= knl_data_d;
      err_q      <= err_d;
      eop_q      <= eop_d;
      img_len_q  <= img_len_d;
      gpio_q     <= gpio_d;
      vconv_q    <= vconv_d;
      vfsm_q     <= vfsm_d;
      load_q     <= load_d;
      pend_q     <= pend_d;
    end
  end

  assign o_GPIOdata      = gpio_q;
  assign o_KNLdata       = knl_data_q;
  assign o_knl_idx       = knl_idx_q;
  assign o_valid_to_CONV = vconv_q;
  assign o_valid_to_FSM  = vfsm_q;
  assign o_load          = load_q;
  assign o_run           = (state_q == S_RUN);
  assign o_KNorIMG       = (state_q == S_RUN);
  assign o_EOP_to_MCU    = eop_q;
  assign o_error         = err_q;
  assign o_imgLength     = img_len_q;
  assign o_state         = state_q;

endmodule

// File: tb/tb_conv_ctrl_block.sv
// Bench for conv_ctrl_block: directed scenarios plus a randomized command stream
// checked against a command-level behavioural model.
module tb_conv_ctrl_block;

  logic        clk;
  logic        i_rst;
  logic [23:0] i_GPIOdata;
  logic [2:0]  i_GPIOctrl;
  logic        i_GPIOvalid;
  logic [12:0] i_MCUdata;
  logic        i_EOP_from_FSM;
  logic [31:0] o_GPIOdata;
  logic [23:0] o_KNLdata;
  logic [1:0]  o_knl_idx;
  logic        o_valid_to_CONV, o_valid_to_FSM, o_load;
  logic        o_run, o_EOP_to_MCU, o_KNorIMG, o_error;
  logic [9:0]  o_imgLength;
  logic [2:0]  o_state;

  conv_ctrl_block dut (
    .i_CLK           (clk),
    .i_rst           (i_rst),
    .i_GPIOdata      (i_GPIOdata),
    .i_GPIOctrl      (i_GPIOctrl),
    .i_GPIOvalid     (i_GPIOvalid),
    .i_MCUdata       (i_MCUdata),
    .i_EOP_from_FSM  (i_EOP_from_FSM),
    .o_GPIOdata      (o_GPIOdata),
    .o_KNLdata       (o_KNLdata),
    .o_knl_idx       (o_knl_idx),
    .o_valid_to_CONV (o_valid_to_CONV),
    .o_valid_to_FSM  (o_valid_to_FSM),
    .o_load          (o_load),
    .o_run           (o_run),
    .o_EOP_to_MCU    (o_EOP_to_MCU),
    .o_KNorIMG       (o_KNorIMG),
    .o_error         (o_error),
    .o_imgLength     (o_imgLength),
    .o_state         (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model, advanced one command at a time
  logic [2:0]  m_state;
  int          m_cnt;
  bit          m_full, m_err, m_eop;
  logic [9:0]  m_len;
  logic [23:0] m_kdata;
  logic [1:0]  m_kidx;
  logic [31:0] m_gpio;
  bit          e_conv, e_fsm, e_load;

  // Samples one cycle (c1) and two cycles (c2) after strobe detection
  bit          c1_conv, c1_fsm, c1_load, c1_err;
  bit          c2_conv, c2_fsm, c2_load;
  logic [31:0] c1_gpio, c2_gpio;
  logic [1:0]  c1_kidx;
  logic [23:0] c1_kdata;

  task automatic model_reset(input bit keep_len);
    m_state = 3'd0; m_cnt = 0; m_full = 0; m_err = 0; m_eop = 0;
    m_kdata = '0; m_kidx = '0; m_gpio = '0;
    if (!keep_len) m_len = '0;
  endtask

  task automatic model_apply(input int op, input logic [23:0] data, input logic [12:0] mcu,
                             input bit eop);
    logic [2:0] pre;
    int v;
    pre = m_state;
    e_conv = 0; e_fsm = 0; e_load = 0;
    if (op == 5) begin
      model_reset(1'b1);
    end else begin
      if (m_state != 3'd3) begin
        case (op)
          0: if (m_state == 3'd0 || m_state == 3'd1 || m_state == 3'd4) begin
               m_kdata = data; m_kidx = 2'(m_cnt); e_conv = 1;
               m_cnt = m_cnt + 1;
               if (m_cnt == 3) begin m_cnt = 0; m_full = 1; end
               m_state = 3'd1;
             end else m_err = 1;
          1: begin
               v = int'(data % 24'd1024);
               if (v >= 1 && v <= 1023) m_len = 10'(v); else m_err = 1;
             end
          2: begin e_load = (m_state != 3'd2); e_fsm = 1; m_eop = 0; m_state = 3'd2; end
          3: if (m_state == 3'd4) begin e_fsm = 1; m_gpio = {19'd0, mcu}; end else m_err = 1;
          4: if (m_state == 3'd2 && m_full && m_len != 0) m_state = 3'd3; else m_err = 1;
          6: begin
               m_gpio = {m_state, m_err, m_full, (m_state == 3'd3), m_eop, 15'd0, m_len};
               m_err = 0;
             end
          default: m_err = 1;
        endcase
      end
      if (eop && pre == 3'd3) begin m_state = 3'd4; m_eop = 1; end
    end
  endtask

  task automatic send(input int op, input logic [23:0] data, input bit eop = 1'b0);
    model_apply(op, data, i_MCUdata, eop);
    @(negedge clk);
    i_GPIOctrl = op[2:0]; i_GPIOdata = data; i_GPIOvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_EOP_from_FSM = eop;
    @(posedge clk); #1;
    c1_conv = o_valid_to_CONV; c1_fsm = o_valid_to_FSM; c1_load = o_load; c1_err = o_error;
    c1_gpio = o_GPIOdata; c1_kidx = o_knl_idx; c1_kdata = o_KNLdata;
    @(negedge clk);
    i_GPIOvalid = 1'b0; i_EOP_from_FSM = 1'b0;
    @(posedge clk); #1;
    c2_conv = o_valid_to_CONV; c2_fsm = o_valid_to_FSM; c2_load = o_load; c2_gpio = o_GPIOdata;
  endtask

  task automatic eop_pulse();
    if (m_state == 3'd3) begin m_state = 3'd4; m_eop = 1; end
    @(negedge clk); i_EOP_from_FSM = 1'b1;
    @(negedge clk); i_EOP_from_FSM = 1'b0;
  endtask

  task automatic go_run_seq();
    send(5, 24'd0);
    for (int i = 0; i < 3; i++) send(0, 24'($urandom));
    send(1, 24'($urandom_range(1, 1023)));
    send(2, 24'd0);
    send(4, 24'd0);
  endtask

  task automatic test_reset();
    i_rst = 1'b0; i_GPIOvalid = 1'b1; i_GPIOctrl = 3'd7; i_GPIOdata = '0;
    i_MCUdata = '0; i_EOP_from_FSM = 1'b0;
    model_reset(1'b0);
    #23;
    n_vec++;
    if ({o_GPIOdata, o_KNLdata, o_knl_idx, o_valid_to_CONV, o_valid_to_FSM, o_load, o_run,
         o_EOP_to_MCU, o_KNorIMG, o_error, o_imgLength, o_state} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got nonzero gpio=%h st=%0d err=%b required all 0",
                        o_GPIOdata, o_state, o_error);
    end
    @(negedge clk); i_rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if (o_error !== 1'b0 || o_state !== 3'd0) begin
      n_err++; $display("FAIL reset_release_level: err=%b st=%0d required 0/0", o_error, o_state);
    end
    @(negedge clk); i_GPIOvalid = 1'b0; i_GPIOctrl = 3'd0;
    @(posedge clk);
  endtask

  task automatic test_knl_load();
    logic [23:0] rows [3];
    rows[0] = 24'h010203; rows[1] = 24'h040506; rows[2] = 24'h070809;
    for (int i = 0; i < 3; i++) begin
      send(0, rows[i]);
      n_vec++;
      if (c1_conv !== 1'b1 || c2_conv !== 1'b0) begin
        n_err++; $display("FAIL knl_pulse%0d: got %b%b required 10", i, c1_conv, c2_conv);
      end
      n_vec++;
      if (c1_kidx !== 2'(i) || c1_kdata !== rows[i]) begin
        n_err++; $display("FAIL knl_row%0d: got idx %0d data %h required %0d %h",
                          i, c1_kidx, c1_kdata, i, rows[i]);
      end
    end
    send(6, 24'd0);
    n_vec++;
    if (c1_gpio[27] !== 1'b1 || c1_gpio[31:29] !== 3'd1) begin
      n_err++; $display("FAIL knl_full: status %h required full=1 state=1", c1_gpio);
    end
  endtask

  task automatic test_errors();
    send(5, 24'd0);
    send(2, 24'd0);
    send(4, 24'd0);
    n_vec++;
    if (o_error !== 1'b1 || o_state !== 3'd2) begin
      n_err++; $display("FAIL gorun_nofull: err=%b st=%0d required 1/2", o_error, o_state);
    end
    send(6, 24'd0);
    n_vec++;
    if (c1_gpio[28] !== 1'b1 || c1_err !== 1'b0) begin
      n_err++; $display("FAIL status_clear: bit=%b err=%b required 1/0", c1_gpio[28], c1_err);
    end
    send(1, 24'd512);
    send(1, 24'd0);
    n_vec++;
    if (o_imgLength !== 10'd512 || o_error !== 1'b1) begin
      n_err++; $display("FAIL imglen_zero: len=%0d err=%b required 512/1", o_imgLength, o_error);
    end
    send(6, 24'd0);
    send(1, 24'd1024);
    n_vec++;
    if (o_imgLength !== 10'd512 || o_error !== 1'b1) begin
      n_err++; $display("FAIL imglen_1024: len=%0d err=%b required 512/1", o_imgLength, o_error);
    end
    send(1, 24'd1023);
    n_vec++;
    if (o_imgLength !== 10'd1023) begin
      n_err++; $display("FAIL imglen_max: len=%0d required 1023", o_imgLength);
    end
    send(7, 24'd0);
    send(5, 24'd0);
    n_vec++;
    if (o_error !== 1'b0 || o_imgLength !== 10'd1023) begin
      n_err++; $display("FAIL softreset_keep: err=%b len=%0d required 0/1023", o_error, o_imgLength);
    end
  endtask

  task automatic test_run_flow();
    int nload, nfsm;
    send(5, 24'd0);
    for (int i = 0; i < 3; i++) send(0, 24'(i * 3 + 1));
    send(1, 24'd512);
    nload = 0; nfsm = 0;
    for (int i = 0; i < 4; i++) begin
      send(2, 24'($urandom));
      nload += int'(c1_load) + int'(c2_load);
      nfsm  += int'(c1_fsm) + int'(c2_fsm);
    end
    n_vec++;
    if (nload != 1 || nfsm != 4) begin
      n_err++; $display("FAIL img_pulses: load=%0d fsm=%0d required 1/4", nload, nfsm);
    end
    send(4, 24'd0);
    n_vec++;
    if (o_run !== 1'b1 || o_KNorIMG !== 1'b1 || o_state !== 3'd3) begin
      n_err++; $display("FAIL go_run: run=%b kn=%b st=%0d required 1/1/3", o_run, o_KNorIMG, o_state);
    end
    send(0, 24'hABCDEF);
    n_vec++;
    if (c1_conv !== 1'b0 || o_error !== 1'b0 || o_state !== 3'd3) begin
      n_err++; $display("FAIL run_ignore: conv=%b err=%b st=%0d required 0/0/3", c1_conv, o_error, o_state);
    end
    eop_pulse();
    #1;
    n_vec++;
    if (o_state !== 3'd4 || o_EOP_to_MCU !== 1'b1 || o_run !== 1'b0 || o_KNorIMG !== 1'b0) begin
      n_err++; $display("FAIL eop: st=%0d eop=%b run=%b required 4/1/0", o_state, o_EOP_to_MCU, o_run);
    end
    i_MCUdata = 13'h1ABC;
    send(3, 24'd0);
    n_vec++;
    if (c1_fsm !== 1'b1 || c2_gpio !== 32'h00001ABC) begin
      n_err++; $display("FAIL data_req: fsm=%b gpio=%h required 1/00001abc", c1_fsm, c2_gpio);
    end
  endtask

  task automatic test_softreset_eop();
    go_run_seq();
    send(5, 24'd0, 1'b1);
    n_vec++;
    if (o_state !== 3'd0 || o_EOP_to_MCU !== 1'b0) begin
      n_err++; $display("FAIL softreset_vs_eop: st=%0d eop=%b required 0/0", o_state, o_EOP_to_MCU);
    end
  endtask

  task automatic test_reset_midrun();
    go_run_seq();
    @(posedge clk); #2;
    i_rst = 1'b0;
    #1;
    n_vec++;
    if ({o_run, o_KNorIMG, o_EOP_to_MCU, o_error, o_state, o_imgLength, o_KNLdata, o_GPIOdata} !== '0) begin
      n_err++; $display("FAIL async_reset: run=%b st=%0d len=%0d required all 0", o_run, o_state, o_imgLength);
    end
    model_reset(1'b0);
    @(negedge clk); i_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({o_valid_to_CONV, o_valid_to_FSM, o_load, o_run} !== 4'b0) begin
        n_err++; $display("FAIL release_pulse%0d: got %b required 0000", i,
                          {o_valid_to_CONV, o_valid_to_FSM, o_load, o_run});
      end
    end
  endtask

  task automatic test_random();
    int op;
    logic [23:0] data;
    bit run;
    for (int it = 0; it < 200; it++) begin
      i_MCUdata = 13'($urandom);
      if (m_state == 3'd3 && $urandom_range(0, 2) == 0) begin
        eop_pulse();
        #1;
        n_vec++;
        if (o_state !== m_state || o_EOP_to_MCU !== m_eop) begin
          n_err++; $display("FAIL rnd_eop%0d: st=%0d eop=%b required %0d/%b", it, o_state,
                            o_EOP_to_MCU, m_state, m_eop);
        end
      end else begin
        op = int'($urandom_range(0, 7));
        if (op == 5 && $urandom_range(0, 3) != 0) op = 0;
        data = (op == 1) ? 24'($urandom_range(0, 1100)) : 24'($urandom);
        send(op, data);
        run = (m_state == 3'd3);
        n_vec++;
        if ({c1_conv, c1_fsm, c1_load} !== {e_conv, e_fsm, e_load}) begin
          n_err++; $display("FAIL rnd_pulse%0d op%0d: got %b required %b", it, op,
                            {c1_conv, c1_fsm, c1_load}, {e_conv, e_fsm, e_load});
        end
        n_vec++;
        if ({c2_conv, c2_fsm, c2_load} !== 3'b000) begin
          n_err++; $display("FAIL rnd_pulsewidth%0d: got %b required 000", it, {c2_conv, c2_fsm, c2_load});
        end
        n_vec++;
        if (c2_gpio !== m_gpio) begin
          n_err++; $display("FAIL rnd_gpio%0d op%0d: got %h required %h", it, op, c2_gpio, m_gpio);
        end
        n_vec++;
        if ({o_state, o_error, o_run, o_KNorIMG, o_EOP_to_MCU} !== {m_state, m_err, run, run, m_eop}) begin
          n_err++; $display("FAIL rnd_ctrl%0d op%0d: got %b required %b", it, op,
                            {o_state, o_error, o_run, o_KNorIMG, o_EOP_to_MCU},
                            {m_state, m_err, run, run, m_eop});
        end
        n_vec++;
        if ({o_KNLdata, o_knl_idx, o_imgLength} !== {m_kdata, m_kidx, m_len}) begin
          n_err++; $display("FAIL rnd_regs%0d: got %h/%0d/%0d required %h/%0d/%0d", it, o_KNLdata,
                            o_knl_idx, o_imgLength, m_kdata, m_kidx, m_len);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_knl_load();
    test_errors();
    test_run_flow();
    test_softreset_eop();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
